bus_cycle_seq: RTL and testbench
================================

Name: bus_cycle_seq

Overview:
- Control-side partner of the register/ALU datapath.
- Consumes the decoded instruction info word (chk_i) and sequences 8085-style machine cycles (M1 opcode fetch, then M2..M5) and T-states.
- Drives the datapath enable vector (ienb) and the external bus strobes (ale, rd_, wr_, iom, hlta).
- Sits between the datapath core and the memory/IO bus interface.

Parameters:
- INSTSIZE, 17, width of the decoded instruction info word.
- IENBSIZE, 6, width of the datapath enable vector.
- MCYCBITS, 3, width of the machine-cycle index output.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- chk_i  input  17  decoded info: [0] GO6, [1] DAD, [2] HLT, [3] DIO, [7:4] extra-cycle mask, [11:8] write mask, [15:12] data-pointer mask, [16] condition flag.
- ready  input  1  bus ready; low during T2/TW inserts wait states.
- ienb  output  6  [0] RRD, [1] RWR, [2] COD, [3] DAT, [4] PC_, [5] PD_.
- ale  output  1  address latch enable, high in T1.
- rd_  output  1  active-low read strobe.
- wr_  output  1  active-low write strobe.
- iom  output  1  high for an IO bus cycle.
- hlta  output  1  high while halted.
- mcyc  output  3  current machine cycle, 0 = M1 .. 4 = M5.

Behaviour:
- Reset and clocking:
  - One clock; reset is synchronous and active-high.
  - While rst is high: state = T1, mcyc = 0, latched info cleared, ienb = 0, ale = 0, rd_ = 1, wr_ = 1, iom = 0, hlta = 0.
  - The first T1 appears in the first clock after rst falls.
  - rst asserted mid-cycle (any T-state, including HALT or TW) aborts at the next edge; no partial write strobes survive.
- States: T1, T2, TW, T3, T4, T5, T6, HALT.
- Outputs are a Moore decode of the registered state, mcyc and the latched info.
- M1 (opcode fetch):
  - T1: ale = 1, PD_ = 0.
  - T2: rd_ = 0. If ready = 0, go to TW; stay in TW while ready = 0 (rd_ stays low).
  - T3: rd_ = 0, COD = 1, PC_ = 1.
  - T4: chk_i is valid. Latch [15:4] into a remaining-cycle mask and DIO/HLT/GO6 into flags.
  - T4 → T5 if GO6, else leave M1.
  - T5 → T6.
  - If the extra-cycle mask is 0, pulse RRD = 1 and RWR = 1 in the final M1 state (T4 or T6). This is register writeback.
- Mn (n = 2..5), entered only when the cycle-mask bit n-2 is 1:
  - T1: ale = 1; PD_ = data-pointer bit n-2.
  - T2: read cycle → rd_ = 0; write cycle (write bit n-2 = 1) → wr_ = 0 and RRD = 1. TW handling is the same as M1.
  - T3, read cycle: rd_ = 0, DAT = 1, PC_ = ~data-pointer bit.
  - T3, write cycle: wr_ = 0, RRD = 1.
  - If this is the last set bit and the cycle is a read, RWR = 1 in T3.
- IO cycles: iom = 1 throughout the last Mn of an instruction whose DIO flag is set; 0 otherwise.
- Transitions after the last T-state of a cycle:
  - Next set mask bit → next Mn, and mcyc takes that index.
  - No set bit remaining → M1 T1, mcyc = 0.
  - Mask bits are consumed low to high. Gaps in the mask (e.g. 4'b0101) skip the unset cycles.
- Halt:
  - HLT flag set: complete any pending cycles, then enter HALT.
  - In HALT: hlta = 1, all strobes inactive, ienb = 0. Exit only by rst.
- ready is sampled only in T2/TW. It is ignored in all other states.
- The condition flag (bit 16) is latched but does not shorten cycles; conditional skip is out of scope for this block.

Decomposition:
- Shared package:
  - ienb bit indices (IENB_RRD..IENB_PD_).
  - chk_i field positions (INST_GO6, INST_DAD, INST_HLT, INST_DIO, INST_CYL/CYH, INST_RWL/RWH, INST_CDL/CDH, INST_CCC).
  - T-state encodings.
- Sub-module cyc_mask_next: combinational priority picker that returns the next set mask bit index plus a none-left flag.

Test Plan:
- rst high 3 clocks, then low, chk_i = 0 (NOP), ready = 1 → outputs inactive during reset; then repeating 4-clock M1: ale in T1, rd_ low T2–T3, COD + PC_ in T3, RRD + RWR in T4; mcyc stays 0.
- chk_i mask = 4'b0001, write = 0, data-pointer = 1 (MOV r,M) → M1 then 3-clock M2 with PD_ = 1, DAT = 1 and RWR = 1 in T3, PC_ = 0; mcyc = 1 during M2.
- chk_i mask = 4'b0011, write = 4'b0010, DIO = 1 (OUT) → M2 read with PC_ = 1 in T3; M3 with wr_ low T2–T3, RRD = 1, iom = 1 only in M3.
- GO6 = 1, mask = 4'b0011, write = 4'b0011 (RST-like) → M1 lasts 6 clocks; M2 and M3 are both write cycles.
- ready = 0 for 2 clocks in M1 T2 → two TW states, rd_ stays low, COD asserted only in the T3 after ready returns to 1.
- HLT = 1 with mask = 4'b0001 → one M2 read, then HALT with hlta = 1 and all strobes idle indefinitely; rst in HALT → M1 T1 after release.

Source files
------------

// File: rtl/bus_cycle_seq_pkg.sv
// Shared field positions, enable-bit indices and T-state encodings for the 8085-style machine-cycle sequencer.
package bus_cycle_seq_pkg;

  localparam int INSTSIZE = 17;
  localparam int IENBSIZE = 6;
  localparam int MCYCBITS = 3;
  localparam int NMCYC    = 4;

  localparam int IENB_RRD = 0;
  localparam int IENB_RWR = 1;
  localparam int IENB_COD = 2;
  localparam int IENB_DAT = 3;
  localparam int IENB_PC_ = 4;
  localparam int IENB_PD_ = 5;

  localparam int INST_GO6 = 0;
  localparam int INST_DAD = 1;
  localparam int INST_HLT = 2;
  localparam int INST_DIO = 3;
  localparam int INST_CYL = 4;
  localparam int INST_CYH = 7;
  localparam int INST_RWL = 8;
  localparam int INST_RWH = 11;
  localparam int INST_CDL = 12;
  localparam int INST_CDH = 15;
  localparam int INST_CCC = 16;

  typedef enum logic [2:0] {
    ST_T1, ST_T2, ST_TW, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } tstate_t;

endpackage

// File: rtl/bus_cycle_seq_if.sv
// Decoded-instruction input, bus ready, and the strobe/enable outputs of the cycle sequencer.
interface bus_cycle_seq_if
  import bus_cycle_seq_pkg::*;
#(
  parameter int INSTSIZE = bus_cycle_seq_pkg::INSTSIZE,
  parameter int IENBSIZE = bus_cycle_seq_pkg::IENBSIZE,
  parameter int MCYCBITS = bus_cycle_seq_pkg::MCYCBITS
);
  logic [INSTSIZE-1:0] chk_i;
  logic                ready;
  logic [IENBSIZE-1:0] ienb;
  logic                ale;
  logic                rd_;
  logic                wr_;
  logic                iom;
  logic                hlta;
  logic [MCYCBITS-1:0] mcyc;

  modport master (
    input  chk_i, ready,
    output ienb, ale, rd_, wr_, iom, hlta, mcyc
  );

  modport slave (
    output chk_i, ready,
    input  ienb, ale, rd_, wr_, iom, hlta, mcyc
  );
endinterface

// File: rtl/bus_cycle_seq_cyc_mask_next.sv
// Combinational picker: index of the lowest set bit in the remaining-cycle mask, and a none-left flag.
module bus_cycle_seq_cyc_mask_next
  import bus_cycle_seq_pkg::*;
(
  input  logic [NMCYC-1:0] mask,
  output logic [1:0]       idx,
  output logic             none
);
  always_comb begin
    idx  = 2'd0;
    none = 1'b1;
    // Scan downward so the lowest set bit is the one that sticks.
    for (int i = NMCYC - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx  = 2'(i);
        none = 1'b0;
      end
    end
  end
endmodule

// File: rtl/bus_cycle_seq.sv
// Machine-cycle / T-state sequencer: M1 fetch plus masked M2..M5, driving bus strobes and datapath enables.
// Outputs are a Moore decode of registered state; ready stretches T2 via TW wait states.
module bus_cycle_seq
  import bus_cycle_seq_pkg::*;
#(
  parameter int INSTSIZE = bus_cycle_seq_pkg::INSTSIZE,
  parameter int IENBSIZE = bus_cycle_seq_pkg::IENBSIZE,
  parameter int MCYCBITS = bus_cycle_seq_pkg::MCYCBITS
)(
  input  logic             clk,
  input  logic             rst,
  bus_cycle_seq_if.master  bus
);

  tstate_t             state, state_nxt;
  logic [MCYCBITS-1:0] mcyc_q;
  logic [NMCYC-1:0]    rem_q, wr_q, dp_q;
  logic                dio_q, hlt_q, go6_q, ccc_q;

  logic [INSTSIZE-1:0] chk;
  logic [NMCYC-1:0]    mask_src;
  logic [1:0]          nxt_idx, cur;
  logic                none_left, hlt_sel, end_cyc, is_m1, last;

  logic [IENBSIZE-1:0] ienb;
  logic                ale, rd_, wr_, iom, hlta;
  logic                unused_bits;

  assign chk = bus.chk_i;
  assign unused_bits = ^{chk[INST_DAD], go6_q, ccc_q};

  // In T4 the info word is live on chk_i; afterwards only the latched copy is valid.
  assign mask_src = (state == ST_T4) ? chk[INST_CYH:INST_CYL] : rem_q;
  assign hlt_sel  = (state == ST_T4) ? chk[INST_HLT] : hlt_q;

  bus_cycle_seq_cyc_mask_next u_next (
    .mask (mask_src),
    .idx  (nxt_idx),
    .none (none_left)
  );

  assign is_m1 = (mcyc_q == '0);
  assign cur   = mcyc_q[1:0] - 2'd1;
  assign last  = (rem_q == '0);

  always_comb begin
    state_nxt = state;
    end_cyc   = 1'b0;
    case (state)
      ST_T1:        state_nxt = ST_T2;
      ST_T2, ST_TW: state_nxt = bus.ready ? ST_T3 : ST_TW;
      ST_T3: begin
        if (is_m1) state_nxt = ST_T4;
        else       end_cyc   = 1'b1;
      end
      ST_T4: begin
        if (chk[INST_GO6]) state_nxt = ST_T5;
        else               end_cyc   = 1'b1;
      end
      ST_T5:   state_nxt = ST_T6;
      ST_T6:   end_cyc   = 1'b1;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_T1;
    endcase
    if (end_cyc) begin
      if (none_left && hlt_sel) state_nxt = ST_HALT;
      else                      state_nxt = ST_T1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_T1;
      mcyc_q <= '0;
      rem_q  <= '0;
      wr_q   <= '0;
      dp_q   <= '0;
      dio_q  <= 1'b0;
      hlt_q  <= 1'b0;
      go6_q  <= 1'b0;
      ccc_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_T4) begin
        rem_q <= chk[INST_CYH:INST_CYL];
        wr_q  <= chk[INST_RWH:INST_RWL];
        dp_q  <= chk[INST_CDH:INST_CDL];
        dio_q <= chk[INST_DIO];
        hlt_q <= chk[INST_HLT];
        go6_q <= chk[INST_GO6];
        ccc_q <= chk[INST_CCC];
      end
      if (end_cyc) begin
        if (none_left) begin
          mcyc_q <= '0;
        end else begin
          rem_q  <= mask_src & ~(NMCYC'(1) << nxt_idx);
          mcyc_q <= MCYCBITS'(nxt_idx) + MCYCBITS'(1);
        end
      end
    end
  end

  always_comb begin
    ienb = '0;
    ale  = 1'b0;
    rd_  = 1'b1;
    wr_  = 1'b1;
    iom  = 1'b0;
    hlta = 1'b0;
    if (!rst) begin
      if (state == ST_HALT) begin
        hlta = 1'b1;
      end else if (is_m1) begin
        case (state)
          ST_T1:        ale = 1'b1;
          ST_T2, ST_TW: rd_ = 1'b0;
          ST_T3: begin
            rd_            = 1'b0;
            ienb[IENB_COD] = 1'b1;
            ienb[IENB_PC_] = 1'b1;
          end
          ST_T4: begin
            ienb[IENB_RRD] = (chk[INST_CYH:INST_CYL] == '0) && !chk[INST_GO6];
            ienb[IENB_RWR] = (chk[INST_CYH:INST_CYL] == '0) && !chk[INST_GO6];
          end
          ST_T6: begin
            ienb[IENB_RRD] = (rem_q == '0);
            ienb[IENB_RWR] = (rem_q == '0);
          end
          default: ;
        endcase
      end else begin
        iom = dio_q && last;
        case (state)
          ST_T1: begin
            ale            = 1'b1;
            ienb[IENB_PD_] = dp_q[cur];
          end
          ST_T2, ST_TW, ST_T3: begin
            if (wr_q[cur]) begin
              wr_            = 1'b0;
              ienb[IENB_RRD] = 1'b1;
            end else begin
              rd_ = 1'b0;
              if (state == ST_T3) begin
                ienb[IENB_DAT] = 1'b1;
                ienb[IENB_PC_] = !dp_q[cur];
                ienb[IENB_RWR] = last;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.ienb = ienb;
  assign bus.ale  = ale;
  assign bus.rd_  = rd_;
  assign bus.wr_  = wr_;
  assign bus.iom  = iom;
  assign bus.hlta = hlta;
  assign bus.mcyc = rst ? '0 : mcyc_q;

endmodule

// File: tb/tb_bus_cycle_seq.sv
// Randomized scoreboard bench for bus_cycle_seq: per-clock expected outputs from a machine-cycle model.
module tb_bus_cycle_seq;

  localparam int TS_RST  = 0;
  localparam int TS_T1   = 1;
  localparam int TS_T2   = 2;
  localparam int TS_TW   = 3;
  localparam int TS_T3   = 4;
  localparam int TS_T4   = 5;
  localparam int TS_T5   = 6;
  localparam int TS_T6   = 7;
  localparam int TS_HALT = 8;

  typedef struct {
    logic [13:0] vec;
    logic [13:0] mask;
    int          mc;
    int          ts;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic [16:0] cur_chk = '0;
  exp_t  exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  bus_cycle_seq_if bus ();

  bus_cycle_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Expected outputs for one clock, written straight from the bus-cycle rules.
  function automatic exp_t mk(int mc, int ts, logic [16:0] c, bit last);
    exp_t e;
    logic [5:0] ie;
    logic a, r, w, io, h;
    int k;
    bit wrc, dp;
    ie = '0; a = 0; r = 1; w = 1; io = 0; h = 0;
    if (ts == TS_HALT) begin
      h = 1;
    end else if (ts == TS_RST) begin
      h = 0;
    end else if (mc == 0) begin
      if (ts == TS_T1) a = 1;
      if (ts == TS_T2 || ts == TS_TW) r = 0;
      if (ts == TS_T3) begin r = 0; ie[2] = 1; ie[4] = 1; end
      if (ts == TS_T4 && c[7:4] == 0 && !c[0]) begin ie[0] = 1; ie[1] = 1; end
      if (ts == TS_T6 && c[7:4] == 0) begin ie[0] = 1; ie[1] = 1; end
    end else begin
      k   = mc - 1;
      wrc = c[8 + k];
      dp  = c[12 + k];
      io  = c[3] & last;
      if (ts == TS_T1) begin a = 1; ie[5] = dp; end
      else if (wrc) begin w = 0; ie[0] = 1; end
      else begin
        r = 0;
        if (ts == TS_T3) begin ie[3] = 1; ie[4] = !dp; ie[1] = last; end
      end
    end
    e.vec  = {ie, a, r, w, io, h, 3'(mc)};
    e.mask = (ts == TS_HALT) ? 14'h3ff8 : 14'h3fff;
    e.mc   = mc;
    e.ts   = ts;
    return e;
  endfunction

  task automatic step(input logic rs, input logic rdy, input exp_t e);
    @(posedge clk);
    #1;
    rst       = rs;
    bus.ready = rdy;
    bus.chk_i = cur_chk;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'($urandom_range(0, 1)), mk(0, TS_RST, cur_chk, 0));
  endtask

  // m1w < 0 picks M1 wait states at random; abort_at >= 0 asserts rst at that clock of the instruction.
  task automatic run_instr(input logic [16:0] c, input int m1w, input int abort_at);
    int  ts_q[$];
    int  mc_q[$];
    bit  lst_q[$];
    logic rdy_q[$];
    int  n;
    cur_chk = c;
    for (int m = 0; m < 5; m++) begin
      int w;
      bit last;
      if (m > 0 && !c[3 + m]) continue;
      w = (m == 0 && m1w >= 0) ? m1w : (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
      last = (m > 0) && ((c[7:4] >> m) == 0);
      ts_q.push_back(TS_T1); mc_q.push_back(m); lst_q.push_back(last); rdy_q.push_back(1'($urandom_range(0, 1)));
      ts_q.push_back(TS_T2); mc_q.push_back(m); lst_q.push_back(last); rdy_q.push_back(w == 0);
      for (int j = 0; j < w; j++) begin
        ts_q.push_back(TS_TW); mc_q.push_back(m); lst_q.push_back(last); rdy_q.push_back(j == w - 1);
      end
      ts_q.push_back(TS_T3); mc_q.push_back(m); lst_q.push_back(last); rdy_q.push_back(1'($urandom_range(0, 1)));
      if (m == 0) begin
        ts_q.push_back(TS_T4); mc_q.push_back(0); lst_q.push_back(0); rdy_q.push_back(1'($urandom_range(0, 1)));
        if (c[0]) begin
          ts_q.push_back(TS_T5); mc_q.push_back(0); lst_q.push_back(0); rdy_q.push_back(1'($urandom_range(0, 1)));
          ts_q.push_back(TS_T6); mc_q.push_back(0); lst_q.push_back(0); rdy_q.push_back(1'($urandom_range(0, 1)));
        end
      end
    end
    n = (abort_at >= 0 && abort_at < ts_q.size()) ? abort_at : ts_q.size();
    for (int i = 0; i < n; i++) step(1'b0, rdy_q[i], mk(mc_q[i], ts_q[i], c, lst_q[i]));
    if (n < ts_q.size()) begin
      do_reset(2);
    end else if (c[2]) begin
      for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom_range(0, 1)), mk(0, TS_HALT, c, 0));
      do_reset(2);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [13:0] got;
      e   = exp_q.pop_front();
      got = {bus.ienb, bus.ale, bus.rd_, bus.wr_, bus.iom, bus.hlta, bus.mcyc};
      n_cmp++;
      if ((got & e.mask) !== (e.vec & e.mask)) begin
        n_bad++;
        $display("FAIL outputs mc=%0d ts=%0d t=%0t: got ienb/ale/rd_/wr_/iom/hlta/mcyc=%b required %b (care %b)",
                 e.mc, e.ts, $time, got, e.vec, e.mask);
      end
    end
  end

  initial begin
    logic [16:0] c;
    int ab;
    bus.ready = 1'b1;
    bus.chk_i = '0;
    do_reset(3);
    run_instr(17'h00000, 0, -1);
    run_instr(17'h00000, 0, -1);
    run_instr(17'h01010, 0, -1);
    run_instr(17'h00238, 0, -1);
    run_instr(17'h00331, 0, -1);
    run_instr(17'h00000, 2, -1);
    run_instr(17'h00014, 0, -1);
    run_instr(17'h00000, 0, -1);
    run_instr(17'h00331, 0, 6);
    run_instr(17'h00238, 1, 10);
    for (int i = 0; i < 60; i++) begin
      c    = 17'($urandom);
      c[2] = ($urandom_range(0, 7) == 0);
      ab   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 12)) : -1;
      run_instr(c, -1, ab);
    end
    run_instr(17'h00000, 0, -1);
    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
